// File: rtl/cla_response_checker.sv
// Response checker for a carry-lookahead adder: compares {cout,sum} with a+b+cin
// over a valid/ready stream, keeps pass/fail statistics and captures the first mismatch.
module cla_response_checker #(
  parameter int WIDTH       = 4,
  parameter int NUM_VECTORS = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_vld,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH:0]   first_fail_exp,
  output logic             done,
  output logic             all_pass
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  localparam logic [CNT_W-1:0] NUM     = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] accepted;
  logic             s1_vld;
  logic [CNT_W-1:0] s1_idx;
  logic [WIDTH:0]   s1_exp;
  logic [WIDTH:0]   s1_got;
  logic [WIDTH:0]   exp_sum;
  logic             xfer;

  // Expected result keeps the full carry out of the top bit.
  assign exp_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign in_ready = (state == RUN) && (accepted < NUM);
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      accepted       <= '0;
      s1_vld         <= 1'b0;
      s1_idx         <= '0;
      s1_exp         <= '0;
      s1_got         <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      done           <= 1'b0;
      all_pass       <= 1'b0;
    end else if (start) begin
      // A start in any state wipes the run, including any compare still in flight.
      state          <= RUN;
      accepted       <= '0;
      s1_vld         <= 1'b0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      done           <= 1'b0;
      all_pass       <= 1'b0;
    end else begin
      s1_vld <= xfer;
      if (xfer) begin
        s1_idx   <= accepted;
        s1_exp   <= exp_sum;
        s1_got   <= {dut_cout, dut_sum};
        accepted <= accepted + ONE;
      end

      if (s1_vld) begin
        if (s1_exp == s1_got) begin
          if (pass_count != CNT_MAX) pass_count <= pass_count + ONE;
        end else begin
          if (fail_count != CNT_MAX) fail_count <= fail_count + ONE;
          if (!first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_idx <= s1_idx;
            first_fail_exp <= s1_exp;
          end
        end
      end

      // RUN lingers one cycle after the last transfer so CHECK sees final counts.
      case (state)
        RUN:     if (accepted == NUM) state <= CHECK;
        CHECK: begin
          state    <= DONE;
          done     <= 1'b1;
          all_pass <= (fail_count == '0);
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_response_checker.sv
// Directed bench for cla_response_checker: known-good and deliberately broken
// adder responses, checked with immediate assertions against hand-derived results.
module tb_cla_response_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a, b, dut_sum;
  logic       cin, dut_cout;
  logic [7:0] pass_count, fail_count, first_fail_idx;
  logic       first_fail_vld, done, all_pass;
  logic [4:0] first_fail_exp;

  int n_checks = 0;
  int n_fail   = 0;

  cla_response_checker #(.WIDTH(4), .NUM_VECTORS(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .dut_sum(dut_sum), .dut_cout(dut_cout),
    .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx),
    .first_fail_exp(first_fail_exp), .done(done), .all_pass(all_pass)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drives one pair at a negedge, holds it until accepted, returns at the next negedge.
  task automatic apply_stimulus(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                                input logic [4:0] got);
    int guard = 0;
    a = va; b = vb; cin = vc; {dut_cout, dut_sum} = got; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_output("in_ready_wait", {31'b0, in_ready}, 1);
    @(negedge clk);
  endtask

  // Vector i: a=i+14, b=i+15, cin=i[1] (vector 5 is 3+4+0). Errors flip bit 0 of the result.
  task automatic run_vectors(input int first, input int count, input int err0, input int err1,
                             input bit gaps);
    logic [3:0] va, vb;
    logic       vc;
    logic [4:0] good;
    for (int i = first; i < first + count; i++) begin
      va   = 4'(i + 14);
      vb   = 4'(i + 15);
      vc   = 1'((i >> 1) & 1);
      good = {1'b0, va} + {1'b0, vb} + {4'b0, vc};
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      apply_stimulus(va, vb, vc, (i == err0 || i == err1) ? (good ^ 5'b00001) : good);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!done && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check_output("done", {31'b0, done}, 1);
  endtask

  task automatic check_zero(input string tag);
    check_output({tag, "_pass"}, {24'b0, pass_count}, 0);
    check_output({tag, "_fail"}, {24'b0, fail_count}, 0);
    check_output({tag, "_ffv"}, {31'b0, first_fail_vld}, 0);
    check_output({tag, "_done"}, {31'b0, done}, 0);
    check_output({tag, "_allpass"}, {31'b0, all_pass}, 0);
    check_output({tag, "_ready"}, {31'b0, in_ready}, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; dut_sum = '0; dut_cout = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    check_output("reset_ffidx", {24'b0, first_fail_idx}, 0);
    check_output("reset_ffexp", {27'b0, first_fail_exp}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("idle_ready", {31'b0, in_ready}, 0);

    // Clean run, back-to-back, with exact latency and done timing.
    pulse_start();
    check_output("run_ready", {31'b0, in_ready}, 1);
    apply_stimulus(4'd14, 4'd15, 1'b0, 5'd29);
    check_output("lat_n1_pass", {24'b0, pass_count}, 0);
    apply_stimulus(4'd15, 4'd0, 1'b0, 5'd15);
    check_output("lat_n2_pass", {24'b0, pass_count}, 1);
    run_vectors(2, 14, -1, -1, 1'b0);
    check_output("t1_done_e0", {31'b0, done}, 0);
    @(negedge clk);
    check_output("t1_done_e1", {31'b0, done}, 0);
    check_output("t1_pass_e1", {24'b0, pass_count}, 16);
    @(negedge clk);
    check_output("t1_done_e2", {31'b0, done}, 1);
    check_output("t1_pass", {24'b0, pass_count}, 16);
    check_output("t1_fail", {24'b0, fail_count}, 0);
    check_output("t1_allpass", {31'b0, all_pass}, 1);
    check_output("t1_ffv", {31'b0, first_fail_vld}, 0);
    check_output("t1_ready", {31'b0, in_ready}, 0);

    // Errors on vectors 5 and 9.
    pulse_start();
    check_output("t2_cleared", {24'b0, pass_count}, 0);
    run_vectors(0, 16, 5, 9, 1'b0);
    wait_done();
    check_output("t2_pass", {24'b0, pass_count}, 14);
    check_output("t2_fail", {24'b0, fail_count}, 2);
    check_output("t2_ffv", {31'b0, first_fail_vld}, 1);
    check_output("t2_ffidx", {24'b0, first_fail_idx}, 5);
    check_output("t2_ffexp", {27'b0, first_fail_exp}, 32'h07);
    check_output("t2_allpass", {31'b0, all_pass}, 0);

    // Full-carry overflow: F+F+1 = 5'b11111.
    pulse_start();
    apply_stimulus(4'hF, 4'hF, 1'b1, 5'b11111);
    apply_stimulus(4'hF, 4'hF, 1'b1, 5'b01111);
    run_vectors(2, 14, -1, -1, 1'b0);
    wait_done();
    check_output("t3_pass", {24'b0, pass_count}, 15);
    check_output("t3_fail", {24'b0, fail_count}, 1);
    check_output("t3_ffidx", {24'b0, first_fail_idx}, 1);
    check_output("t3_ffexp", {27'b0, first_fail_exp}, 32'h1F);

    // Random gaps, then a bad pair held valid while not ready.
    pulse_start();
    run_vectors(0, 16, -1, -1, 1'b1);
    a = 4'd1; b = 4'd1; cin = 1'b0; {dut_cout, dut_sum} = 5'd9; in_valid = 1'b1;
    check_output("t4_ready_full", {31'b0, in_ready}, 0);
    repeat (6) @(negedge clk);
    wait_done();
    check_output("t4_pass", {24'b0, pass_count}, 16);
    check_output("t4_fail", {24'b0, fail_count}, 0);
    check_output("t4_ready_done", {31'b0, in_ready}, 0);
    repeat (3) @(negedge clk);
    check_output("t4_pass_hold", {24'b0, pass_count}, 16);
    in_valid = 1'b0;

    // Abort after 7 transfers with an error at index 2.
    pulse_start();
    run_vectors(0, 7, 2, -1, 1'b0);
    check_output("t5_pre_fail", {24'b0, fail_count}, 1);
    pulse_start();
    check_output("t5_abort_pass", {24'b0, pass_count}, 0);
    check_output("t5_abort_fail", {24'b0, fail_count}, 0);
    check_output("t5_abort_ffv", {31'b0, first_fail_vld}, 0);
    run_vectors(0, 16, -1, -1, 1'b0);
    wait_done();
    check_output("t5_pass", {24'b0, pass_count}, 16);
    check_output("t5_ffv", {31'b0, first_fail_vld}, 0);
    check_output("t5_allpass", {31'b0, all_pass}, 1);

    // Asynchronous reset mid-run, asserted and released between edges.
    pulse_start();
    run_vectors(0, 5, -1, -1, 1'b0);
    check_output("t6_pre_pass", {24'b0, pass_count}, 4);
    #2 rst_n = 1'b0;
    #1 check_zero("t6_async");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_zero("t6_after");
    pulse_start();
    run_vectors(0, 16, -1, -1, 1'b0);
    wait_done();
    check_output("t6_pass", {24'b0, pass_count}, 16);
    check_output("t6_allpass", {31'b0, all_pass}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
